// File: rtl/mem_byte_seq.sv
// Load/store byte sequencer: splits one RV32I load/store into 1, 2 or 4 little-endian
// byte accesses on an 8-bit synchronous memory and assembles/extends load data.
module mem_byte_seq #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dina,
  input  logic [7:0]        mem_douta
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        r_funct3;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_lanes;
  logic [1:0]        r_idx;
  logic [1:0]        r_last;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_mem_ena;
  logic              r_mem_wea;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BYTE_W-1:0] r_mem_dina;

  logic [2:0]        w_state_nxt;
  logic [2:0]        w_funct3_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [DATA_W-1:0] w_lanes_nxt;
  logic [1:0]        w_idx_nxt;
  logic [1:0]        w_last_nxt;
  logic              w_resp_valid_nxt;
  logic              w_resp_err_nxt;
  logic [DATA_W-1:0] w_resp_rdata_nxt;
  logic              w_mem_ena_nxt;
  logic              w_mem_wea_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [BYTE_W-1:0] w_mem_dina_nxt;

  logic [1:0]        w_size;
  logic [1:0]        w_last;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_unused_addr;

  assign w_unused_addr = ^req_addr[31:ADDR_W];

  // Request decode: byte count and error classification
  assign w_size     = req_funct3[1:0];
  assign w_last     = (w_size == 2'b00) ? 2'd0 : ((w_size == 2'b01) ? 2'd1 : 2'd3);
  assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_we && req_funct3[2]);
  assign w_misalign = ((w_size == 2'b01) && req_addr[0]) ||
                      ((w_size == 2'b10) && (req_addr[1:0] != 2'b00));

  function automatic logic [DATA_W-1:0] put_lane(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] idx,
                                                 input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = v;
    case (idx)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      2'd3: r[31:24] = b;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3,
                                               input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    case (f3)
      3'b000:  r = {{24{v[7]}}, v[7:0]};
      3'b100:  r = {24'h0, v[7:0]};
      3'b001:  r = {{16{v[15]}}, v[15:0]};
      3'b101:  r = {16'h0, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_funct3_nxt     = r_funct3;
    w_wdata_nxt      = r_wdata;
    w_lanes_nxt      = r_lanes;
    w_idx_nxt        = r_idx;
    w_last_nxt       = r_last;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = '0;
    w_mem_ena_nxt    = 1'b0;
    w_mem_wea_nxt    = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_dina_nxt   = r_mem_dina;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_funct3_nxt = req_funct3;
          w_wdata_nxt  = req_wdata;
          w_lanes_nxt  = '0;
          w_idx_nxt    = 2'd0;
          w_last_nxt   = w_last;
          if (w_illegal || w_misalign) begin
            w_state_nxt      = S_ERR;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
          end else begin
            w_mem_ena_nxt  = 1'b1;
            w_mem_wea_nxt  = req_we;
            w_mem_addr_nxt = req_addr[ADDR_W-1:0];
            if (req_we) begin
              w_mem_dina_nxt = req_wdata[7:0];
              w_state_nxt    = S_WRITE;
            end else begin
              w_state_nxt    = S_READ;
            end
          end
        end
      end
      S_WRITE: begin
        if (r_idx == r_last) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
        end else begin
          w_idx_nxt      = r_idx + 2'd1;
          w_mem_ena_nxt  = 1'b1;
          w_mem_wea_nxt  = 1'b1;
          w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
          w_mem_dina_nxt = r_wdata[15:8];
          w_wdata_nxt    = {8'h00, r_wdata[31:8]};
        end
      end
      S_READ: begin
        // Data for the byte issued last cycle is on mem_douta now
        if (r_idx != 2'd0) begin
          w_lanes_nxt = put_lane(r_lanes, r_idx - 2'd1, mem_douta);
        end
        if (r_idx == r_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_idx_nxt      = r_idx + 2'd1;
          w_mem_ena_nxt  = 1'b1;
          w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        w_lanes_nxt      = put_lane(r_lanes, r_idx, mem_douta);
        w_resp_rdata_nxt = extend(r_funct3, w_lanes_nxt);
        w_resp_valid_nxt = 1'b1;
        w_state_nxt      = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_funct3     <= 3'b000;
      r_wdata      <= '0;
      r_lanes      <= '0;
      r_idx        <= 2'd0;
      r_last       <= 2'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_ena    <= 1'b0;
      r_mem_wea    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_dina   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_funct3     <= w_funct3_nxt;
      r_wdata      <= w_wdata_nxt;
      r_lanes      <= w_lanes_nxt;
      r_idx        <= w_idx_nxt;
      r_last       <= w_last_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_ena    <= w_mem_ena_nxt;
      r_mem_wea    <= w_mem_wea_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_dina   <= w_mem_dina_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_ena    = r_mem_ena;
  assign mem_wea    = r_mem_wea;
  assign mem_addr   = r_mem_addr;
  assign mem_dina   = r_mem_dina;

endmodule

// File: tb/tb_mem_byte_seq.sv
// Directed bench for mem_byte_seq with a behavioural 8-bit synchronous memory.
module tb_mem_byte_seq;

  localparam int unsigned ADDR_W = 13;

  logic              clka = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_ena;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dina;
  logic [7:0]        mem_douta;

  logic [7:0] mem [0:8191];

  int errors = 0;
  int checks = 0;

  mem_byte_seq #(.ADDR_W(ADDR_W)) dut (
    .clka(clka), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  always #5 clka = ~clka;

  // Read-first synchronous byte memory
  always @(posedge clka) begin
    if (mem_ena) begin
      if (mem_wea) mem[mem_addr] <= mem_dina;
      mem_douta <= mem[mem_addr];
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'hA5;
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    tick();
    checks++; if ({req_ready, resp_valid, resp_err} !== 3'b100) begin errors++;
      $display("FAIL reset_flags: got %b want 100", {req_ready, resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h want 00000000", resp_rdata); end
    checks++; if ({mem_ena, mem_wea} !== 2'b00) begin errors++;
      $display("FAIL reset_mem_en: got %b want 00", {mem_ena, mem_wea}); end
    checks++; if (mem_addr !== 13'h0) begin errors++;
      $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_dina !== 8'h0) begin errors++;
      $display("FAIL reset_dina: got %h want 00", mem_dina); end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_word();
    logic [31:0] wd;
    logic [22:0] exp_m;
    wd = 32'hDEADBEEF;
    drive(1'b1, 3'b010, 32'h0000_0010, wd);
    for (int i = 0; i < 4; i++) begin
      exp_m = {1'b1, 1'b1, ADDR_W'(16 + i), wd[8*i +: 8]};
      checks++; if ({mem_ena, mem_wea, mem_addr, mem_dina} !== exp_m) begin errors++;
        $display("FAIL sw_byte%0d: got %h want %h", i, {mem_ena, mem_wea, mem_addr, mem_dina}, exp_m); end
      checks++; if ({req_ready, resp_valid} !== 2'b00) begin errors++;
        $display("FAIL sw_busy%0d: got %b want 00", i, {req_ready, resp_valid}); end
      tick();
    end
    checks++; if ({resp_valid, resp_err, mem_ena, mem_wea, req_ready} !== 5'b10000) begin errors++;
      $display("FAIL sw_resp: got %b want 10000", {resp_valid, resp_err, mem_ena, mem_wea, req_ready}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++;
      $display("FAIL sw_rdata: got %h want 00000000", resp_rdata); end
    tick();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++;
      $display("FAIL sw_idle: got %b want 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_load_word();
    logic [14:0] exp_m;
    drive(1'b0, 3'b010, 32'hABCD_0010, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_m = {1'b1, 1'b0, ADDR_W'(16 + i)};
      checks++; if ({mem_ena, mem_wea, mem_addr} !== exp_m || resp_valid !== 1'b0) begin errors++;
        $display("FAIL lw_issue%0d: got %h/%b want %h/0", i, {mem_ena, mem_wea, mem_addr}, resp_valid, exp_m); end
      tick();
    end
    checks++; if ({mem_ena, resp_valid} !== 2'b00) begin errors++;
      $display("FAIL lw_drain: got %b want 00", {mem_ena, resp_valid}); end
    tick();
    checks++; if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL lw_resp: got %b/%h want 10/deadbeef", {resp_valid, resp_err}, resp_rdata); end
    tick();
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] exp_d;
    int          n;
    logic        early;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin f3 = 3'b000; a = 32'h13; n = 1; exp_d = 32'hFFFFFFDE; end
        1: begin f3 = 3'b100; a = 32'h13; n = 1; exp_d = 32'h000000DE; end
        2: begin f3 = 3'b001; a = 32'h12; n = 2; exp_d = 32'hFFFFDEAD; end
        default: begin f3 = 3'b101; a = 32'h10; n = 2; exp_d = 32'h0000BEEF; end
      endcase
      drive(1'b0, f3, a, 32'h0);
      early = 1'b0;
      for (int c = 1; c <= n + 1; c++) begin
        if (resp_valid !== 1'b0) early = 1'b1;
        tick();
      end
      checks++; if (early !== 1'b0) begin errors++;
        $display("FAIL ext%0d_early: got resp_valid before cycle %0d", k, n + 2); end
      checks++; if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== exp_d) begin errors++;
        $display("FAIL ext%0d_resp: got %b/%h want 10/%h", k, {resp_valid, resp_err}, resp_rdata, exp_d); end
      tick();
    end
  endtask

  task automatic test_errors();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin we = 1'b1; f3 = 3'b001; a = 32'h11; end
        1: begin we = 1'b0; f3 = 3'b010; a = 32'h1E; end
        2: begin we = 1'b0; f3 = 3'b011; a = 32'h10; end
        default: begin we = 1'b1; f3 = 3'b100; a = 32'h10; end
      endcase
      drive(we, f3, a, 32'h12345678);
      checks++; if ({resp_valid, resp_err, req_ready, mem_ena} !== 4'b1100 || resp_rdata !== 32'h0) begin errors++;
        $display("FAIL err%0d_resp: got %b/%h want 1100/00000000", k, {resp_valid, resp_err, req_ready, mem_ena}, resp_rdata); end
      tick();
      checks++; if ({resp_valid, req_ready, mem_ena} !== 3'b010) begin errors++;
        $display("FAIL err%0d_after: got %b want 010", k, {resp_valid, req_ready, mem_ena}); end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive(1'b1, 3'b010, 32'h20, 32'h44332211);
    tick();
    tick();
    checks++; if ({mem_ena, mem_addr} !== {1'b1, 13'h22}) begin errors++;
      $display("FAIL rstmid_cyc3: got %h want %h", {mem_ena, mem_addr}, {1'b1, 13'h22}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, resp_valid, resp_err, mem_ena, mem_wea} !== 5'b10000 ||
                  mem_addr !== 13'h0 || mem_dina !== 8'h0 || resp_rdata !== 32'h0) begin errors++;
      $display("FAIL rstmid_outs: got %b/%h/%h/%h", {req_ready, resp_valid, resp_err, mem_ena, mem_wea},
               mem_addr, mem_dina, resp_rdata); end
    tick();
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL rstmid_dropped: got resp_valid after reset want none"); end
    drive(1'b0, 3'b010, 32'h20, 32'h0);
    for (int c = 0; c < 5; c++) tick();
    checks++; if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'h86872211) begin errors++;
      $display("FAIL rstmid_lw: got %b/%h want 10/86872211", {resp_valid, resp_err}, resp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0000_1FFF; req_wdata = 32'hA5A5A55A;
    tick();
    req_we = 1'b0; req_funct3 = 3'b100; req_wdata = 32'h0;
    checks++; if ({mem_ena, mem_wea, mem_addr, mem_dina, req_ready} !== {1'b1, 1'b1, 13'h1FFF, 8'h5A, 1'b0}) begin errors++;
      $display("FAIL b2b_sb: got %h", {mem_ena, mem_wea, mem_addr, mem_dina, req_ready}); end
    tick();
    checks++; if ({resp_valid, resp_err, req_ready} !== 3'b100) begin errors++;
      $display("FAIL b2b_sb_resp: got %b want 100", {resp_valid, resp_err, req_ready}); end
    tick();
    checks++; if ({resp_valid, req_ready, mem_ena} !== 3'b010) begin errors++;
      $display("FAIL b2b_idle: got %b want 010", {resp_valid, req_ready, mem_ena}); end
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_ena, mem_wea, mem_addr, req_ready} !== {1'b1, 1'b0, 13'h1FFF, 1'b0}) begin errors++;
      $display("FAIL b2b_lbu_issue: got %h", {mem_ena, mem_wea, mem_addr, req_ready}); end
    tick();
    checks++; if ({mem_ena, resp_valid} !== 2'b00) begin errors++;
      $display("FAIL b2b_drain: got %b want 00", {mem_ena, resp_valid}); end
    tick();
    checks++; if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== 32'h0000005A) begin errors++;
      $display("FAIL b2b_lbu: got %b/%h want 10/0000005a", {resp_valid, resp_err}, resp_rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_word();
    test_load_ext();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_byte_seq.md
Name: mem_byte_seq

Overview:
- Load/store sequencer between the RV32I MEM stage and the 8-bit-wide data memory `mimic_mem` (13-bit byte address, synchronous 1-cycle read).
- Accepts one RV32I load/store per request and issues 1, 2 or 4 byte accesses, little-endian.
- For loads, assembles and sign/zero-extends the bytes into a 32-bit result.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
ADDR_W, 13, memory byte-address width; `req_addr[ADDR_W-1:0]` is used, upper bits are ignored.

Ports:
clka  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data (low bytes used for SB/SH)
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  misaligned/illegal, qualified by resp_valid
resp_rdata  out  32  load result; 0 for stores and errors
mem_ena  out  1  memory enable
mem_wea  out  1  memory write enable
mem_addr  out  ADDR_W  memory byte address
mem_dina  out  8  memory write byte
mem_douta  in  8  memory read byte, valid 1 cycle after read issue

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_ena=0, mem_wea=0, mem_addr=0, mem_dina=0.
- Output timing: all mem_* and resp_* outputs are driven from registers. req_ready = (state==IDLE).
- Accept: req_valid & req_ready at a rising edge. Call the cycle after that edge cycle 1. The block latches addr/we/funct3/wdata.
- Access size N (from funct3[1:0]): 00 → 1 byte, 01 → 2, 10 → 4.
- Error cases:
  - Illegal: funct3 ∈ {011,110,111}, or a store with funct3[2]=1.
  - Misaligned: N=2 with addr[0]=1, or N=4 with addr[1:0]≠0.
  - Either case → state ERR: resp_valid=1, resp_err=1, resp_rdata=0 in cycle 1. mem_ena stays 0 throughout.
- States: IDLE, WRITE, READ, DRAIN, RESP, ERR.
- WRITE (cycles 1..N):
  - mem_ena=1, mem_wea=1, mem_addr=base+i, mem_dina=wdata[8i+7:8i], for i=0..N-1.
  - After the last byte → RESP in cycle N+1: resp_valid=1, resp_err=0, resp_rdata=0.
- READ (cycles 1..N):
  - mem_ena=1, mem_wea=0, mem_addr=base+i.
  - The byte issued in cycle k is captured from mem_douta at the end of cycle k+1 into byte lane k-1.
  - DRAIN (cycle N+1): mem_ena=0; captures the last byte.
  - RESP (cycle N+2): resp_valid=1, resp_rdata = extended result.
- Load extension:
  - LB: sign-extend bit 7. LBU: zero-extend.
  - LH: sign-extend bit 15. LHU: zero-extend. LW: as assembled.
- Latency from accept to resp_valid: store N+1, load N+2, error 1. SW=5, LW=6.
- RESP/ERR last exactly one cycle, then IDLE. There is no response backpressure.
- Next request: req_ready=0 from cycle 1 through the RESP/ERR cycle. The earliest next accept is the edge ending the first IDLE cycle after the response.
- Address arithmetic: mem_addr = base+i, ADDR_W bits wide, modulo 2^ADDR_W. Aligned accesses never wrap; the top word 8188..8191 is legal.
- Idle/drain/resp/err: mem_ena=0, mem_wea=0. mem_addr and mem_dina hold their last value.
- Reset mid-operation:
  - Immediate return to IDLE; any pending response is dropped.
  - Bytes already written stay in memory (no rollback).
- req_* inputs are ignored while req_ready=0.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF → cycles 1–4 write EF,BE,AD,DE to 0x10–0x13 with mem_ena=mem_wea=1. Cycle 5: resp_valid=1, resp_err=0, resp_rdata=0.
- LW 0x10 after the SW above → reads 0x10–0x13 in cycles 1–4, cycle 5 mem_ena=0. Cycle 6: resp_valid=1, resp_rdata=0xDEADBEEF.
- LB 0x13 → 0xFFFFFFDE at cycle 3. LBU 0x13 → 0x000000DE. LH 0x12 → 0xFFFFDEAD at cycle 4. LHU 0x10 → 0x0000BEEF.
- SH addr 0x11, LW addr 0x1E, and funct3=011 load → each gives resp_valid=resp_err=1 in cycle 1, resp_rdata=0, and mem_ena never asserts.
- SW addr 0x20, wdata 0x44332211, rst_n low during cycle 3 → all outputs go to reset values immediately with no resp_valid. A later LW 0x20 shows bytes 0x20–0x21 = 11,22 and 0x22–0x23 unchanged.
- Back-to-back: req_valid held high with SB 0x1FFF=0x5A then LBU 0x1FFF → second accept one IDLE cycle after the first response. Result 0x0000005A, no address wrap.
